// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer encode/decode blocks.
//   N_BITS       binary code width
//   THERMO_W     thermometer width, 2**N_BITS-1
//   ramp_state_t ramp FSM states
//   bin2thermo   binary level -> thermometer code, (1<<level)-1
package thermo_pkg;

    localparam int unsigned N_BITS   = 4;
    localparam int unsigned THERMO_W = (1 << N_BITS) - 1;

    typedef enum logic [0:0] {
        StIdle,
        StRamp
    } ramp_state_t;

    function automatic logic [THERMO_W-1:0] bin2thermo(input logic [N_BITS-1:0] lvl);
        logic [THERMO_W:0] one_hot;
        logic [THERMO_W:0] mask;
        one_hot      = '0;
        one_hot[lvl] = 1'b1;
        // One-hot at bit lvl minus one leaves ones in bits [lvl-1:0].
        mask = one_hot - {{THERMO_W{1'b0}}, 1'b1};
        return mask[THERMO_W-1:0];
    endfunction

endpackage

// File: rtl/bin_to_thermo.sv
// Purely combinational binary-to-thermometer encoder.
//   bin     binary level, 0..THERMO_W
//   thermo  thermometer code, bits [bin-1:0] set
module bin_to_thermo
    import thermo_pkg::*;
(
    input  logic [N_BITS-1:0]   bin,
    output logic [THERMO_W-1:0] thermo
);

    always_comb begin
        thermo = bin2thermo(bin);
    end

endmodule

// File: rtl/thermo_ramp_encoder.sv
// Slew-limited binary-to-thermometer encoder. Accepts a binary target over
// valid/ready and walks the registered thermometer output toward it one level
// per clock, so exactly one thermometer bit toggles per cycle.
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  in_bin holds a new target
//   in_ready  target can be accepted this cycle (state IDLE)
//   in_bin    binary target level
//   thermo    registered thermometer code, equal to (1<<level)-1
//   level     current binary level
//   busy      ramp in progress
//   done      one-cycle pulse when level reaches the accepted target
module thermo_ramp_encoder
    import thermo_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_BITS-1:0]   in_bin,
    output logic [THERMO_W-1:0] thermo,
    output logic [N_BITS-1:0]   level,
    output logic                busy,
    output logic                done
);

    ramp_state_t          state_q, state_d;
    logic [N_BITS-1:0]    level_q, level_d;
    logic [N_BITS-1:0]    target_q, target_d;
    logic [THERMO_W-1:0]  thermo_q, thermo_d;
    logic                 done_q, done_d;

    // Thermometer code is derived from the next level so it moves in the same
    // edge as level and cannot drift from it.
    bin_to_thermo u_bin_to_thermo (
        .bin    (level_d),
        .thermo (thermo_d)
    );

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    target_d = in_bin;
                    if (in_bin == level_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRamp;
                    end
                end
            end
            StRamp: begin
                // Entering RAMP guarantees target != level, so no wrap can occur.
                if (target_q > level_q) begin
                    level_d = level_q + 1'b1;
                end else begin
                    level_d = level_q - 1'b1;
                end
                if (level_d == target_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            level_q  <= '0;
            target_q <= '0;
            thermo_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            thermo_q <= thermo_d;
            done_q   <= done_d;
        end
    end

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q == StRamp);
    assign thermo   = thermo_q;
    assign level    = level_q;
    assign done     = done_q;

endmodule

// File: tb/tb_thermo_ramp_encoder.sv
module tb_thermo_ramp_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_bin;
    logic [14:0] thermo;
    logic [3:0]  level;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    logic        started = 1'b0;
    logic        last_rst = 1'b1;
    logic [14:0] prev_thermo = '0;
    logic [3:0]  model_level = '0;

    thermo_ramp_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bin   (in_bin),
        .thermo   (thermo),
        .level    (level),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference thermometer built bit by bit.
    function automatic logic [14:0] exp_thermo(input int lvl);
        logic [14:0] t;
        t = '0;
        for (int i = 0; i < 15; i++) begin
            if (i < lvl) t[i] = 1'b1;
        end
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants sampled mid-cycle.
    always @(posedge clk) last_rst <= rst;

    always @(negedge clk) begin
        if (started) begin
            check("inv_model", {17'd0, thermo}, {17'd0, exp_thermo(int'(level))});
            check("inv_contig", {17'd0, thermo & (thermo + 15'd1)}, 32'd0);
            if (!last_rst) begin
                check("inv_hamming", {31'd0, ($countones(thermo ^ prev_thermo) > 1)}, 32'd0);
            end
            prev_thermo = thermo;
        end
    end

    // Accept tgt from the current model level and follow the whole ramp.
    task automatic do_ramp(input logic [3:0] tgt);
        int cur;
        int d;
        int dir;
        cur = int'(model_level);
        d   = (int'(tgt) > cur) ? int'(tgt) - cur : cur - int'(tgt);
        dir = (int'(tgt) > cur) ? 1 : -1;
        in_valid = 1'b1;
        in_bin   = tgt;
        tick();
        in_valid = 1'b0;
        if (d == 0) begin
            check("d0_done", {31'd0, done}, 32'd1);
            check("d0_ready", {31'd0, in_ready}, 32'd1);
            check("d0_level", {28'd0, level}, {28'd0, tgt});
        end else begin
            check("acc_busy", {31'd0, busy}, 32'd1);
            check("acc_ready", {31'd0, in_ready}, 32'd0);
            check("acc_done", {31'd0, done}, 32'd0);
            for (int s = 1; s <= d; s++) begin
                tick();
                check("step_level", {28'd0, level}, 32'(cur + dir * s));
                check("step_thermo", {17'd0, thermo}, {17'd0, exp_thermo(cur + dir * s)});
                check("step_done", {31'd0, done}, {31'd0, s == d});
                check("step_busy", {31'd0, busy}, {31'd0, s != d});
                check("step_ready", {31'd0, in_ready}, {31'd0, s == d});
            end
        end
        tick();
        check("post_done", {31'd0, done}, 32'd0);
        check("post_level", {28'd0, level}, {28'd0, tgt});
        model_level = tgt;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bin   = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_thermo", {17'd0, thermo}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        prev_thermo = thermo;
        started     = 1'b1;

        // Zero-distance accept, then 0->3 with hand-written codes.
        do_ramp(4'd0);
        in_valid = 1'b1;
        in_bin   = 4'd3;
        tick();
        in_valid = 1'b0;
        check("r3_ready0", {31'd0, in_ready}, 32'd0);
        tick();
        check("r3_t1", {17'd0, thermo}, 32'h0001);
        check("r3_ready1", {31'd0, in_ready}, 32'd0);
        tick();
        check("r3_t2", {17'd0, thermo}, 32'h0003);
        check("r3_ready2", {31'd0, in_ready}, 32'd0);
        tick();
        check("r3_t3", {17'd0, thermo}, 32'h0007);
        check("r3_done", {31'd0, done}, 32'd1);
        check("r3_level", {28'd0, level}, 32'd3);
        check("r3_ready3", {31'd0, in_ready}, 32'd1);
        tick();
        check("r3_done_clr", {31'd0, done}, 32'd0);
        model_level = 4'd3;

        // Full-scale swings.
        do_ramp(4'd15);
        check("full_top", {17'd0, thermo}, 32'h7fff);
        do_ramp(4'd0);
        check("full_bot", {17'd0, thermo}, 32'h0000);

        // 0->10 while a request for 2 is held; 2 is taken back-to-back.
        in_valid = 1'b1;
        in_bin   = 4'd10;
        tick();
        in_bin = 4'd2;
        for (int s = 1; s <= 10; s++) begin
            tick();
            check("hold_level", {28'd0, level}, 32'(s));
            check("hold_done", {31'd0, done}, {31'd0, s == 10});
        end
        tick();
        in_valid = 1'b0;
        check("hold_acc_busy", {31'd0, busy}, 32'd1);
        check("hold_acc_level", {28'd0, level}, 32'd10);
        for (int s = 1; s <= 8; s++) begin
            tick();
            check("down_level", {28'd0, level}, 32'(10 - s));
            check("down_done", {31'd0, done}, {31'd0, s == 8});
        end
        tick();
        model_level = 4'd2;

        // Reset mid-ramp at level 6 toward 12.
        in_valid = 1'b1;
        in_bin   = 4'd12;
        tick();
        in_valid = 1'b0;
        for (int s = 0; s < 4; s++) tick();
        check("mid_level6", {28'd0, level}, 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_level", {28'd0, level}, 32'd0);
        check("mid_rst_thermo", {17'd0, thermo}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("mid_rst_still", {28'd0, level}, 32'd0);
        check("mid_rst_nodone", {31'd0, done}, 32'd0);

        // Reset beats a simultaneous handshake.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_bin   = 4'd5;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rw_busy", {31'd0, busy}, 32'd0);
        tick();
        check("rw_level", {28'd0, level}, 32'd0);
        check("rw_done", {31'd0, done}, 32'd0);
        model_level = 4'd0;

        // Random target stream.
        for (int i = 0; i < 150; i++) begin
            do_ramp(4'($urandom_range(0, 15)));
        end

        started = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #500000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
